stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control FSM for the six-digit BCD stopwatch chain (mm:ss.cc) built from cascaded 100 Hz decade counters.
- Debounces the two front-panel keys (start/stop, lap/reset) and drives the chain's count enable and clear.
- Freezes the displayed value during lap hold.
- Stops the chain at full scale instead of letting it wrap.

Parameters:
- DEB_TICKS, 2, consecutive clk100hz samples a raw key level must hold before it is accepted (2 = 20 ms).
- MAX_BCD, 24'h595999, full-scale chain value (59:59.99); counting stops here.

Ports:
- rst  input  1  asynchronous, active-low reset.
- clk100hz  input  1  100 Hz system tick clock.
- key_ss_n  input  1  raw start/stop key, active-low, asynchronous to clk100hz.
- key_lr_n  input  1  raw lap/reset key, active-low, asynchronous to clk100hz.
- bcd_in  input  24  live chain value, {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4 bits per digit.
- cnt_en  output  1  enable to the least-significant decade counter.
- cnt_clr_n  output  1  active-low clear pulse to the chain; ANDed externally with rst.
- disp_bcd  output  24  value sent to the display driver.
- state_o  output  3  current FSM state code.
- lap_o  output  1  high while lap hold is active.

Behaviour:
- Reset is rst, asynchronous, active-low; clock is clk100hz.
- Reset values:
  - state = IDLE
  - cnt_clr_n = 1
  - lap register = 0
  - debouncer state = released
  - cnt_en = 0, lap_o = 0, disp_bcd = bcd_in (both combinational, follow state).
- Key path:
  - 2-flop synchroniser, then debounce counter, then falling-edge detect.
  - Result is a 1-cycle press pulse (ss_p, lr_p).
  - One pulse per press; holding the key generates nothing further.
  - Bounce shorter than DEB_TICKS samples is rejected.
- Encodings: IDLE=0, RUN=1, PAUSE=2, LAP=3, FULL=4.
- Transitions on press pulses:
  - IDLE: ss_p goes to RUN; lr_p is ignored.
  - RUN: ss_p goes to PAUSE; lr_p goes to LAP and loads the lap register with bcd_in on that edge.
  - LAP: ss_p goes to PAUSE, releasing the freeze; lr_p goes to RUN, releasing the freeze.
  - PAUSE: ss_p goes to RUN; lr_p goes to IDLE and drives cnt_clr_n low for exactly 1 cycle.
  - FULL: lr_p goes to IDLE with the same 1-cycle clear; ss_p is ignored.
- Simultaneous ss_p and lr_p in the same cycle: ss_p wins and lr_p is discarded.
- cnt_en is combinational: cnt_en = (state == RUN or state == LAP) and (bcd_in != MAX_BCD).
  - The chain therefore never advances past MAX_BCD.
- Full-scale detect: in RUN or LAP, if bcd_in == MAX_BCD, the next edge enters FULL.
  - This takes priority over any press pulse in the same cycle.
  - Entering FULL from LAP releases the freeze.
- disp_bcd = lap register in LAP; otherwise bcd_in.
- lap_o = (state == LAP).
- Clear latency: lr_p in PAUSE or FULL gives cnt_clr_n low on the following cycle; bcd_in reads 0 one cycle after that.
  - Any press that arrives while the clear is in flight is honoured from IDLE.
- Reset mid-operation: the FSM returns to IDLE immediately and the lap register is cleared.
  - The chain is cleared through the external AND of rst.
- state_o is registered and equals the state register directly.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encodings (3-bit localparams)
  - MAX_BCD default
  - digit width constant (4) and digit count (6).
- Natural sub-module: key_debounce. It contains the synchroniser, DEB_TICKS counter and press-pulse edge detect, and is instantiated twice (ss, lr).
- FSM, lap register and output muxing stay in stopwatch_ctrl.

Test Plan:
- Reset released, ss held low 2 ticks, released, chain model counting: state goes 0 to 1, cnt_en = 1, bcd_in advances 000000, 000001, ...
- In RUN at bcd_in = 000512, lr press: state 3, lap_o = 1, disp_bcd stays 000512 while bcd_in keeps counting; second lr press: state 1, disp_bcd tracks bcd_in again.
- ss press in RUN: state 2, cnt_en = 0, bcd_in frozen; lr press: state 0, cnt_clr_n low for exactly 1 cycle, bcd_in = 000000 afterwards.
- Chain preloaded to 595998 in RUN: one increment to 595999, then cnt_en = 0 and state 4; no wrap to 000000; ss ignored; lr clears and returns to 0.
- ss bouncing (1-tick low glitches) yields no state change; ss and lr pulses in the same cycle from RUN give PAUSE only.
- rst asserted in LAP: state 0, lap_o = 0, disp_bcd = bcd_in immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control block: state codes, chain geometry
// and full-scale value.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;
    localparam int DIGIT_N = 6;
    localparam int BCD_W   = DIGIT_W * DIGIT_N;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_LAP   = 3'd3;
    localparam logic [2:0] ST_FULL  = 3'd4;

    localparam logic [BCD_W-1:0] MAX_BCD_DEF = 24'h595999;

    // The chain advances in both RUN and LAP; only the display differs.
    function automatic logic is_counting(input logic [2:0] st);
        return (st == ST_RUN) || (st == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// Front-panel key conditioning: 2-flop synchroniser, hold-time debounce and
// press (falling-edge) detection producing a single-cycle pulse per press.
module key_debounce #(
    parameter int DEB_TICKS = 2
) (
    input  logic clk100hz,
    input  logic rst,
    input  logic key_n,
    output logic press_p
);

    localparam int CNT_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_TICKS - 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    // Bring the raw key into the clock domain; released level is 1.
    always_ff @(posedge clk100hz or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it differs from the accepted one for
    // DEB_TICKS consecutive samples; any return to the old level restarts.
    always_ff @(posedge clk100hz or negedge rst) begin
        if (!rst) begin
            cnt   <= CNT_LOAD;
            deb   <= 1'b1;
            deb_d <= 1'b1;
        end else begin
            deb_d <= deb;
            if (sync2 == deb) begin
                cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
                deb <= sync2;
                cnt <= CNT_LOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Press is the accepted high-to-low transition.
    assign press_p = deb_d & ~deb;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: sequences count enable, chain clear and lap freeze
// from two debounced front-panel keys, and halts the chain at full scale.
//
//   state | meaning
//   IDLE  | chain cleared/stopped, waiting for start
//   RUN   | chain counting, display live
//   PAUSE | chain held, display live
//   LAP   | chain counting, display frozen at lap value
//   FULL  | chain reached full scale, held until reset key
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int               DEB_TICKS = 2,
    parameter logic [BCD_W-1:0] MAX_BCD   = MAX_BCD_DEF
) (
    input  logic             rst,
    input  logic             clk100hz,
    input  logic             key_ss_n,
    input  logic             key_lr_n,
    input  logic [BCD_W-1:0] bcd_in,
    output logic             cnt_en,
    output logic             cnt_clr_n,
    output logic [BCD_W-1:0] disp_bcd,
    output logic [2:0]       state_o,
    output logic             lap_o
);

    logic             ss_p;
    logic             lr_p;
    logic [2:0]       state;
    logic [2:0]       nxt;
    logic             clr_req;
    logic             lap_load;
    logic             at_max;
    logic [BCD_W-1:0] lap_q;

    key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_ss (
        .clk100hz (clk100hz),
        .rst      (rst),
        .key_n    (key_ss_n),
        .press_p  (ss_p)
    );

    key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_lr (
        .clk100hz (clk100hz),
        .rst      (rst),
        .key_n    (key_lr_n),
        .press_p  (lr_p)
    );

    assign at_max = is_counting(state) && (bcd_in == MAX_BCD);

    // State register.
    always_ff @(posedge clk100hz or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next state; full scale outranks keys, and start/stop outranks lap/reset.
    always_comb begin
        nxt      = state;
        clr_req  = 1'b0;
        lap_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_p) nxt = ST_RUN;
            end
            ST_RUN: begin
                if (at_max) begin
                    nxt = ST_FULL;
                end else if (ss_p) begin
                    nxt = ST_PAUSE;
                end else if (lr_p) begin
                    nxt      = ST_LAP;
                    lap_load = 1'b1;
                end
            end
            ST_LAP: begin
                if (at_max)    nxt = ST_FULL;
                else if (ss_p) nxt = ST_PAUSE;
                else if (lr_p) nxt = ST_RUN;
            end
            ST_PAUSE: begin
                if (ss_p) begin
                    nxt = ST_RUN;
                end else if (lr_p) begin
                    nxt     = ST_IDLE;
                    clr_req = 1'b1;
                end
            end
            ST_FULL: begin
                if (!ss_p && lr_p) begin
                    nxt     = ST_IDLE;
                    clr_req = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Lap capture and one-cycle registered chain clear.
    always_ff @(posedge clk100hz or negedge rst) begin
        if (!rst) begin
            lap_q     <= '0;
            cnt_clr_n <= 1'b1;
        end else begin
            cnt_clr_n <= ~clr_req;
            if (lap_load) lap_q <= bcd_in;
        end
    end

    // Outputs decoded from the state register.
    always_comb begin
        cnt_en   = is_counting(state) && (bcd_in != MAX_BCD);
        lap_o    = (state == ST_LAP);
        disp_bcd = (state == ST_LAP) ? lap_q : bcd_in;
        state_o  = state;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a behavioural BCD chain model.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic        clk100hz;
    logic        rst;
    logic        key_ss_n;
    logic        key_lr_n;
    logic [23:0] bcd_in;
    logic        cnt_en;
    logic        cnt_clr_n;
    logic [23:0] disp_bcd;
    logic [2:0]  state_o;
    logic        lap_o;

    logic        pre_en;
    logic [23:0] pre_val;
    logic [23:0] last_bcd;
    logic [23:0] trans_bcd;
    logic [2:0]  prev_st;
    int          clr_lows;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [2:0] st;
        logic       en;
        logic       lap;
        int         clr;
    } exp_t;

    typedef struct {
        logic ss;
        logic lr;
        exp_t e;
    } vec_t;

    vec_t tbl[9];
    exp_t sb[$];

    stopwatch_ctrl dut (
        .rst       (rst),
        .clk100hz  (clk100hz),
        .key_ss_n  (key_ss_n),
        .key_lr_n  (key_lr_n),
        .bcd_in    (bcd_in),
        .cnt_en    (cnt_en),
        .cnt_clr_n (cnt_clr_n),
        .disp_bcd  (disp_bcd),
        .state_o   (state_o),
        .lap_o     (lap_o)
    );

    initial begin
        clk100hz = 1'b0;
        forever #5 clk100hz = ~clk100hz;
    end

    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  d;
        logic [3:0]  lim;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            d   = r[i*4 +: 4];
            if (carry) begin
                if (d >= lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = d + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Cascaded decade chain; clear is the external AND of rst and cnt_clr_n.
    always @(posedge clk100hz or negedge rst) begin
        if (!rst)            bcd_in <= '0;
        else if (!cnt_clr_n) bcd_in <= '0;
        else if (pre_en)     bcd_in <= pre_val;
        else if (cnt_en)     bcd_in <= bcd_inc(bcd_in);
    end

    // Track the chain value seen at each state transition and clear pulses.
    always @(negedge clk100hz) begin
        last_bcd <= bcd_in;
        prev_st  <= state_o;
        if (state_o != prev_st) trans_bcd <= last_bcd;
        if (!cnt_clr_n) clr_lows <= clr_lows + 1;
    end

    task automatic tick();
        @(negedge clk100hz);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press(input logic s, input logic l);
        if (s) key_ss_n = 1'b0;
        if (l) key_lr_n = 1'b0;
        repeat (3) tick();
        key_ss_n = 1'b1;
        key_lr_n = 1'b1;
        repeat (5) tick();
    endtask

    task automatic preload(input logic [23:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        tick();
        pre_en  = 1'b0;
    endtask

    initial begin
        logic [23:0] b;
        int          c0;
        exp_t        e;

        n_chk     = 0;
        n_fail    = 0;
        clr_lows  = 0;
        trans_bcd = '0;
        last_bcd  = '0;
        prev_st   = ST_IDLE;
        pre_en    = 1'b0;
        pre_val   = '0;
        key_ss_n  = 1'b1;
        key_lr_n  = 1'b1;
        rst       = 1'b0;

        tbl[0] = '{1'b0, 1'b1, '{ST_IDLE,  1'b0, 1'b0, 0}};
        tbl[1] = '{1'b1, 1'b0, '{ST_RUN,   1'b1, 1'b0, 0}};
        tbl[2] = '{1'b0, 1'b1, '{ST_LAP,   1'b1, 1'b1, 0}};
        tbl[3] = '{1'b0, 1'b1, '{ST_RUN,   1'b1, 1'b0, 0}};
        tbl[4] = '{1'b0, 1'b1, '{ST_LAP,   1'b1, 1'b1, 0}};
        tbl[5] = '{1'b1, 1'b0, '{ST_PAUSE, 1'b0, 1'b0, 0}};
        tbl[6] = '{1'b1, 1'b0, '{ST_RUN,   1'b1, 1'b0, 0}};
        tbl[7] = '{1'b1, 1'b0, '{ST_PAUSE, 1'b0, 1'b0, 0}};
        tbl[8] = '{1'b0, 1'b1, '{ST_IDLE,  1'b0, 1'b0, 1}};

        repeat (3) tick();
        chk("reset_state", 32'(state_o), 32'(ST_IDLE));
        chk("reset_en", 32'(cnt_en), 0);
        chk("reset_lap", 32'(lap_o), 0);
        chk("reset_clr_n", 32'(cnt_clr_n), 1);
        chk("reset_disp", 32'(disp_bcd), 32'(bcd_in));
        rst = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 9; i++) begin
            if (i == 2) preload(24'h000508);
            c0 = clr_lows;
            sb.push_back(tbl[i].e);
            press(tbl[i].ss, tbl[i].lr);
            e = sb.pop_front();
            chk($sformatf("v%0d_state", i), 32'(state_o), 32'(e.st));
            chk($sformatf("v%0d_en", i), 32'(cnt_en), 32'(e.en));
            chk($sformatf("v%0d_lap", i), 32'(lap_o), 32'(e.lap));
            chk($sformatf("v%0d_clr", i), 32'(clr_lows - c0), 32'(e.clr));
            if (e.st == ST_LAP) begin
                chk($sformatf("v%0d_lapval", i), 32'(disp_bcd), 32'(trans_bcd));
                chk($sformatf("v%0d_frozen", i), 32'(disp_bcd == bcd_in), 0);
            end else begin
                chk($sformatf("v%0d_disp", i), 32'(disp_bcd), 32'(bcd_in));
            end
            if (e.st == ST_RUN) begin
                b = bcd_in;
                tick();
                chk($sformatf("v%0d_count", i), 32'(bcd_in), 32'(bcd_inc(b)));
            end
            if (e.st == ST_PAUSE) begin
                b = bcd_in;
                repeat (3) tick();
                chk($sformatf("v%0d_hold", i), 32'(bcd_in), 32'(b));
            end
            if (e.clr != 0) chk($sformatf("v%0d_zero", i), 32'(bcd_in), 0);
        end

        // Full scale: stop at 59:59.99, ignore start/stop, lap/reset clears.
        press(1'b1, 1'b0);
        chk("full_run", 32'(state_o), 32'(ST_RUN));
        preload(24'h595998);
        repeat (4) tick();
        chk("full_val", 32'(bcd_in), 32'h595999);
        chk("full_state", 32'(state_o), 32'(ST_FULL));
        chk("full_en", 32'(cnt_en), 0);
        press(1'b1, 1'b0);
        chk("full_ss_ign", 32'(state_o), 32'(ST_FULL));
        chk("full_nowrap", 32'(bcd_in), 32'h595999);
        c0 = clr_lows;
        press(1'b0, 1'b1);
        chk("full_exit", 32'(state_o), 32'(ST_IDLE));
        chk("full_clr", 32'(clr_lows - c0), 1);
        chk("full_zero", 32'(bcd_in), 0);

        // Single-tick bounce is rejected.
        repeat (4) begin
            key_ss_n = 1'b0;
            tick();
            key_ss_n = 1'b1;
            tick();
        end
        repeat (6) tick();
        chk("bounce", 32'(state_o), 32'(ST_IDLE));

        // A long hold yields exactly one press.
        key_ss_n = 1'b0;
        repeat (20) tick();
        chk("hold_one", 32'(state_o), 32'(ST_RUN));
        key_ss_n = 1'b1;
        repeat (6) tick();
        chk("hold_rel", 32'(state_o), 32'(ST_RUN));

        // Simultaneous presses from RUN: start/stop wins.
        press(1'b1, 1'b1);
        chk("simul_state", 32'(state_o), 32'(ST_PAUSE));
        chk("simul_lap", 32'(lap_o), 0);
        press(1'b0, 1'b1);
        chk("simul_idle", 32'(state_o), 32'(ST_IDLE));

        // Asynchronous reset while in LAP.
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("rst_pre_lap", 32'(lap_o), 1);
        @(posedge clk100hz);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_state", 32'(state_o), 32'(ST_IDLE));
        chk("rst_lap", 32'(lap_o), 0);
        chk("rst_disp", 32'(disp_bcd), 32'(bcd_in));
        chk("rst_en", 32'(cnt_en), 0);
        #1;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_after", 32'(state_o), 32'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
